// File: rtl/norm_stream_packer_pkg.sv
// Shared types and widths for the normalizer output packer.
// A sample is one float32 word plus its end-of-frame marker.
package norm_stream_packer_pkg;

    localparam int FLOAT_W     = 32;
    localparam int FRAME_CNT_W = 16;

    typedef struct packed {
        logic               last;
        logic [FLOAT_W-1:0] data;
    } sample_t;

endpackage

// File: rtl/norm_stream_packer_fifo.sv
// First-word-fall-through FIFO: block RAM with a registered read feeding a
// one-word output register. level_o counts every word held, output stage included.
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     full_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic [AW:0]      level_q, level_d;
    logic             ram_valid_q, ram_valid_d;
    logic [WIDTH-1:0] ram_data_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q;

    logic full, wr_accept, pop, out_load, rd_issue;

    // Fullness is judged on the pre-edge level, so a write coincident with a
    // pop while full is still dropped.
    assign full      = (level_q == (AW+1)'(DEPTH));
    assign wr_accept = wr_en_i & ~full;
    assign pop       = out_valid_q & rd_ready_i;
    assign out_load  = ram_valid_q & (~out_valid_q | pop);
    assign rd_issue  = (mem_cnt_q != '0) & (~ram_valid_q | out_load);

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= wr_data_i;
        if (rd_issue)  ram_data_q    <= mem[rd_ptr_q];
    end

    always_comb begin
        mem_cnt_d   = mem_cnt_q + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, rd_issue};
        level_d     = level_q + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, pop};
        ram_valid_d = ram_valid_q;
        if (rd_issue)      ram_valid_d = 1'b1;
        else if (out_load) ram_valid_d = 1'b0;
        out_valid_d = out_valid_q;
        if (out_load)      out_valid_d = 1'b1;
        else if (pop)      out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            level_q     <= '0;
            ram_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_issue)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (out_load)  out_data_q <= ram_data_q;
            mem_cnt_q   <= mem_cnt_d;
            level_q     <= level_d;
            ram_valid_q <= ram_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign full_o     = full;
    assign rd_data_o  = out_data_q;
    assign rd_valid_o = out_valid_q;
    assign level_o    = level_q;

endmodule

// File: rtl/norm_stream_packer.sv
// Buffers the normalizer's non-stallable sample stream and re-emits it as an
// AXI-Stream master with tlast framing, sticky error flags and a frame counter.
module norm_stream_packer
    import norm_stream_packer_pkg::*;
#(
    parameter int CNT    = 1000,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = FLOAT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_in_valid,
    input  logic                     frame_end_in,
    input  logic                     clear_err,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     frame_err,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);

    localparam int CNT_W = (CNT > 1) ? $clog2(CNT) : 1;

    logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d, cnt_after_wr;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   fifo_full, rd_valid, is_last, beat;
    logic [DATA_W:0]        rd_word;

    // A beat transfers when tvalid & tready are both high at a rising edge;
    // once tvalid rises it stays high, with tdata/tlast frozen, until that beat.
    assign is_last = (sample_cnt_q == CNT_W'(CNT - 1));
    assign beat    = rd_valid & m_axis_tready;

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (data_in_valid),
        .wr_data_i  ({is_last, data_in}),
        .full_o     (fifo_full),
        .rd_data_o  (rd_word),
        .rd_valid_o (rd_valid),
        .rd_ready_i (m_axis_tready),
        .level_o    (fifo_level)
    );

    always_comb begin
        cnt_after_wr = sample_cnt_q;
        if (data_in_valid) cnt_after_wr = is_last ? '0 : sample_cnt_q + CNT_W'(1);
        sample_cnt_d = cnt_after_wr;
        frame_err_d  = frame_err_q & ~clear_err;
        // A frame end that lands off a frame boundary resynchronises the count.
        if (frame_end_in && (cnt_after_wr != '0)) begin
            frame_err_d  = 1'b1;
            sample_cnt_d = '0;
        end
        overflow_d  = (data_in_valid & fifo_full) | (overflow_q & ~clear_err);
        frame_cnt_d = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, beat & rd_word[DATA_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign m_axis_tdata  = rd_word[DATA_W-1:0];
    assign m_axis_tlast  = rd_word[DATA_W];
    assign m_axis_tvalid = rd_valid;
    assign overflow      = overflow_q;
    assign frame_err     = frame_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_norm_stream_packer.sv
// Bench for norm_stream_packer (CNT=8, DEPTH=16): queue-based reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_norm_stream_packer;
    import norm_stream_packer_pkg::*;

    localparam int CNT   = 8;
    localparam int DEPTH = 16;

    logic        clk, rst_n;
    logic [31:0] data_in;
    logic        data_in_valid, frame_end_in, clear_err, m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, overflow, frame_err;
    logic [4:0]  fifo_level;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    norm_stream_packer #(.CNT(CNT), .DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .frame_end_in  (frame_end_in),
        .clear_err     (clear_err),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .frame_err     (frame_err),
        .frame_cnt     (frame_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Buffer contents as a queue; a word becomes visible at the output two
    // edges after the edge that wrote it.
    typedef struct {
        sample_t s;
        int      t;
    } entry_t;

    entry_t mq[$];
    int     edge_n = 0;
    int     m_sc   = 0;
    int     m_fc   = 0;
    logic   m_ovf  = 1'b0;
    logic   m_ferr = 1'b0;

    function automatic logic head_vis();
        return (mq.size() > 0) && (mq[0].t + 2 <= edge_n);
    endfunction

    task automatic model_step();
        logic   full_pre, pop, ovf_ev, ferr_ev;
        entry_t e;
        if (!rst_n) begin
            mq.delete();
            m_sc = 0; m_fc = 0; m_ovf = 1'b0; m_ferr = 1'b0;
            return;
        end
        full_pre = (mq.size() == DEPTH);
        pop      = head_vis() && m_axis_tready;
        edge_n++;
        ovf_ev  = 1'b0;
        ferr_ev = 1'b0;
        if (pop) begin
            if (mq[0].s.last) m_fc = (m_fc + 1) % 65536;
            void'(mq.pop_front());
        end
        if (data_in_valid) begin
            if (full_pre) ovf_ev = 1'b1;
            else begin
                e.s.last = (m_sc == CNT - 1);
                e.s.data = data_in;
                e.t      = edge_n;
                mq.push_back(e);
            end
            m_sc = (m_sc + 1) % CNT;
        end
        if (frame_end_in && m_sc != 0) begin
            ferr_ev = 1'b1;
            m_sc    = 0;
        end
        m_ovf  = ovf_ev  || (m_ovf  && !clear_err);
        m_ferr = ferr_ev || (m_ferr && !clear_err);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("tvalid", {31'b0, m_axis_tvalid}, {31'b0, head_vis()});
        if (head_vis()) begin
            chk("tdata", m_axis_tdata, mq[0].s.data);
            chk("tlast", {31'b0, m_axis_tlast}, {31'b0, mq[0].s.last});
        end
        chk("fifo_level", {27'b0, fifo_level}, mq.size());
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
        chk("frame_cnt", {16'b0, frame_cnt}, m_fc);
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [31:0] d, input logic fe, input logic ce);
        data_in_valid = v;
        data_in       = d;
        frame_end_in  = fe;
        clear_err     = ce;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        data_in = '0; data_in_valid = 1'b0; frame_end_in = 1'b0;
        clear_err = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("rst_level", {27'b0, fifo_level}, 32'd0);
        chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Full frame, consumer always ready
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h3F80_0000 + i, 1'b0, 1'b0);
            if (i < 2) chk("t1_latency_low", {31'b0, m_axis_tvalid}, 32'd0);
            if (i == 2) begin
                chk("t1_first_valid", {31'b0, m_axis_tvalid}, 32'd1);
                chk("t1_first_data", m_axis_tdata, 32'h3F80_0000);
            end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        idle(4);
        chk("t1_frame_cnt", {16'b0, frame_cnt}, 32'd1);
        chk("t1_frame_err", {31'b0, frame_err}, 32'd0);

        // Backpressure through a whole frame
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h3F80_0000 + i, 1'b0, 1'b0);
        idle(2);
        chk("t2_level", {27'b0, fifo_level}, 32'd8);
        chk("t2_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        chk("t2_head", m_axis_tdata, 32'h3F80_0000);
        m_axis_tready = 1'b1;
        idle(10);
        chk("t2_drained", {27'b0, fifo_level}, 32'd0);
        chk("t2_frame_cnt", {16'b0, frame_cnt}, 32'd2);

        // Overflow: 20 words into a 16-word buffer
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i, 1'b0, 1'b0);
            if (i == 15) chk("t3_ovf_before", {31'b0, overflow}, 32'd0);
            if (i == 16) chk("t3_ovf_set", {31'b0, overflow}, 32'd1);
        end
        chk("t3_level_full", {27'b0, fifo_level}, 32'd16);
        m_axis_tready = 1'b1;
        idle(20);
        chk("t3_frame_cnt", {16'b0, frame_cnt}, 32'd4);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_ovf_cleared", {31'b0, overflow}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_resync_err", {31'b0, frame_err}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);

        // Short frame, then a complete one
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h4000_0000 + i, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_frame_err", {31'b0, frame_err}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h4100_0000 + i, 1'b0, 1'b0);
        idle(4);
        chk("t4_frame_cnt", {16'b0, frame_cnt}, 32'd5);

        // Frame end coincident with the last sample; clear coincident with a drop
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h4200_0000 + i, 1'b0, 1'b0);
        drive(1'b1, 32'h4200_0007, 1'b1, 1'b0);
        chk("t5_no_frame_err", {31'b0, frame_err}, 32'd0);
        idle(3);
        chk("t5_frame_cnt", {16'b0, frame_cnt}, 32'd6);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) drive(1'b1, 32'h4300_0000 + i, 1'b0, 1'b0);
        drive(1'b1, 32'h4300_0011, 1'b0, 1'b1);
        chk("t5_ovf_wins", {31'b0, overflow}, 32'd1);
        m_axis_tready = 1'b1;
        idle(20);

        // Reset while words are queued
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h4400_0000 + i, 1'b0, 1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("t6_level", {27'b0, fifo_level}, 32'd0);
        chk("t6_overflow", {31'b0, overflow}, 32'd0);
        chk("t6_frame_err", {31'b0, frame_err}, 32'd0);
        chk("t6_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h4500_0000 + i, 1'b0, 1'b0);
        idle(4);
        chk("t6_frame_cnt_after", {16'b0, frame_cnt}, 32'd1);

        // Random traffic: heavy backpressure, then light
        for (int i = 0; i < 800; i++) begin
            if (i < 400) m_axis_tready = ($urandom_range(0, 3) == 0);
            else         m_axis_tready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 30) == 0);
        end
        m_axis_tready = 1'b1;
        idle(30);
        chk("final_drained", {27'b0, fifo_level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
